bcd_seg7_sequencer: RTL and testbench

BCD_SEG7_SEQUENCER -- requirements
Module: bcd_seg7_sequencer

---
 rtl/bcd_seg7_sequencer_pkg.sv | 24 ++
 rtl/bcd_seg7_sequencer_if.sv | 11 +
 rtl/bcd_seg7_sequencer_seg7_encode.sv | 16 +
 rtl/bcd_seg7_sequencer.sv | 145 ++++++++++++++
 tb/tb_bcd_seg7_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seg7_sequencer_pkg.sv
// Shared definitions for the BCD seven-segment sequencer: FSM encoding and
// the digit-to-segment table (bit0 = a ... bit6 = g, dp always 0).
package bcd_seg7_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry [0] is the code for digit 0.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [7:0] seg_lookup(input logic [3:0] digit);
        return (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bcd_seg7_sequencer_if.sv
// Write port towards the seg7 register file; a write completes on a rising
// edge with seg_write high and seg_waitrequest low.
interface bcd_seg7_sequencer_if;
    logic       seg_write;
    logic [2:0] seg_address;
    logic [7:0] seg_writedata;
    logic       seg_waitrequest;

    modport master (output seg_write, seg_address, seg_writedata, input seg_waitrequest);
    modport slave  (input seg_write, seg_address, seg_writedata, output seg_waitrequest);
endinterface

// File: rtl/bcd_seg7_sequencer_seg7_encode.sv
// Combinational digit-to-segment encoder; blank or non-decimal digits
// produce the blank code.
module seg7_encode
    import bcd_seg7_sequencer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) seg = seg_lookup(digit);
    end

endmodule

// File: rtl/bcd_seg7_sequencer.sv
// Binary-to-BCD (double dabble, one bit per cycle) followed by one
// seg7 register write per digit, ones digit first.
module bcd_seg7_sequencer
    import bcd_seg7_sequencer_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5,
    parameter int BLANK_LZ  = 0
) (
    input  logic                  s_clk,
    input  logic                  s_reset_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    bcd_seg7_sequencer_if.master  seg
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    state_e                   state_q, state_d;
    logic [BIN_WIDTH-1:0]     bin_q, bin_d;
    logic [DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [DIGITS-1:0][3:0]   adj;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic                     wr_q, wr_d;
    logic [2:0]               addr_q, addr_d;
    logic [7:0]               data_q, data_d;

    logic [2:0]               sel_idx;
    logic [3:0]               sel_digit;
    logic                     sel_blank;
    logic                     lz_run;
    logic [7:0]               enc_seg;

    // The encoder looks at the digit about to be loaded: the current index on
    // the first load, the following one once a write is already in flight.
    assign sel_idx = wr_q ? (idx_q + 3'd1) : idx_q;

    always_comb begin
        lz_run    = 1'b1;
        sel_digit = '0;
        sel_blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (dig_q[i] == 4'd0);
            if (3'(i) == sel_idx) begin
                sel_digit = dig_q[i];
                sel_blank = (BLANK_LZ != 0) && (i != 0) && lz_run;
            end
        end
    end

    seg7_encode u_enc (
        .digit (sel_digit),
        .blank (sel_blank),
        .seg   (enc_seg)
    );

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            adj[i] = (dig_q[i] >= 4'd5) ? dig_q[i] + 4'd3 : dig_q[i];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    dig_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Carries out of the top digit are dropped, leaving the
                // operand modulo 10^DIGITS.
                {dig_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = enc_seg;
                end else if (!seg.seg_waitrequest) begin
                    if (idx_q == 3'(DIGITS - 1)) begin
                        wr_d    = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        addr_d = idx_q + 3'd1;
                        data_d = enc_seg;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign seg.seg_write     = wr_q;
    assign seg.seg_address   = addr_q;
    assign seg.seg_writedata = data_q;

endmodule

// File: tb/tb_bcd_seg7_sequencer.sv
// Scoreboard bench: two DUTs (leading zeros shown / blanked) share stimulus;
// expected writes come from a decimal-arithmetic model.
module tb_bcd_seg7_sequencer;

    localparam int BW = 16;
    localparam int DG = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] bin_in = '0;
    logic          wreq = 1'b0;
    logic          busy_a, done_a, busy_b, done_b;

    bcd_seg7_sequencer_if if_a ();
    bcd_seg7_sequencer_if if_b ();
    assign if_a.seg_waitrequest = wreq;
    assign if_b.seg_waitrequest = wreq;

    bcd_seg7_sequencer #(.BIN_WIDTH(BW), .DIGITS(DG), .BLANK_LZ(0)) dut_a (
        .s_clk(clk), .s_reset_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .seg(if_a));

    bcd_seg7_sequencer #(.BIN_WIDTH(BW), .DIGITS(DG), .BLANK_LZ(1)) dut_b (
        .s_clk(clk), .s_reset_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_b), .done(done_b), .seg(if_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int         stall_left = 0;
    int         stall_cnt = 0;
    logic [2:0] stall_addr = 3'd0;
    bit         rand_stall = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Decimal model: digit i = (v mod 10^DG) / 10^i mod 10.
    task automatic push_exp(input logic [BW-1:0] v);
        int t, p, pw;
        logic [7:0] c;
        pw = 1;
        for (int i = 0; i < DG; i++) pw *= 10;
        t = int'(v) % pw;
        p = 1;
        for (int i = 0; i < DG; i++) begin
            c = tbl[(t / p) % 10];
            qa.push_back({3'(i), c});
            qb.push_back({3'(i), (i > 0 && t / p == 0) ? 8'h00 : c});
            p *= 10;
        end
    endtask

    // Sink stall generator; stall_cnt counts cycles a pending write was held off.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0 && if_a.seg_write && if_a.seg_address == stall_addr) begin
            wreq = 1'b1;
            stall_left--;
        end else if (rand_stall && if_a.seg_write && $urandom_range(0, 3) == 0)
            wreq = 1'b1;
        else
            wreq = 1'b0;
        if (wreq && if_a.seg_write) stall_cnt++;
    end

    task automatic mon(input bit b, input logic w, input logic [2:0] a, input logic [7:0] d);
        logic [10:0] e;
        if (!w) return;
        if ((b ? qb.size() : qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write dut%0d got addr %0d data %02h exp none", b, a, d);
            return;
        end
        e = b ? qb[0] : qa[0];
        chk(b ? "write_b" : "write_a", {21'd0, a, d}, {21'd0, e});
        if (!wreq) begin
            if (b) void'(qb.pop_front());
            else   void'(qa.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0, if_a.seg_write, if_a.seg_address, if_a.seg_writedata);
            mon(1'b1, if_b.seg_write, if_b.seg_address, if_b.seg_writedata);
        end
    end

    task automatic issue(input logic [BW-1:0] v);
        push_exp(v);
        bin_in    = v;
        start     = 1'b1;
        stall_cnt = 0;
    endtask

    task automatic wait_done(input int t0, input bit ign);
        int rel;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (ign && (rel == 5 || rel == 20)) begin
                start  = 1'b1;
                bin_in = BW'($urandom);
            end else if (ign)
                start = 1'b0;
            if (done_a) begin
                chk("latency", rel, BW + DG + 1 + stall_cnt);
                chk("done_b", done_b, 1);
                chk("writes_left_a", qa.size(), 0);
                chk("writes_left_b", qb.size(), 0);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout got none exp done by cycle %0d", t0 + 600);
    endtask

    task automatic run(input logic [BW-1:0] v, input bit ign);
        int t0;
        @(negedge clk);
        issue(v);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", busy_a, 1);
        wait_done(t0, ign);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", {busy_a, busy_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_write", {if_a.seg_write, if_b.seg_write}, 0);
        chk("rst_addr", {if_a.seg_address, if_b.seg_address}, 0);
        chk("rst_data", {if_a.seg_writedata, if_b.seg_writedata}, 0);
    endtask

    initial begin
        int  t0;
        bit  found;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(16'd12345, 1'b0);
        run(16'd65535, 1'b0);
        run(16'd0, 1'b0);

        stall_addr = 3'd2;
        stall_left = 3;
        run(16'd9, 1'b0);
        chk("stall_cycles", stall_cnt, 3);

        run(BW'($urandom), 1'b1);

        // start held through DONE is only taken in the following IDLE cycle
        run(BW'($urandom), 1'b0);
        issue(BW'($urandom));
        t0 = cyc + 2;
        @(negedge clk);
        chk("done_start_ignored", busy_a, 0);
        chk("done_one_cycle", done_a, 0);
        @(negedge clk);
        start = 1'b0;
        chk("idle_start_taken", busy_a, 1);
        wait_done(t0, 1'b0);

        // reset in the middle of the write phase
        @(negedge clk);
        issue(BW'($urandom));
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (if_a.seg_write && if_a.seg_address == 3'd2) found = 1'b1;
        end
        chk("reach_addr2", found, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'd42);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("post_reset_busy", busy_a, 1);
        wait_done(t0, 1'b0);

        rand_stall = 1'b1;
        repeat (20) run(BW'($urandom_range(0, 65535)), 1'b0);
        rand_stall = 1'b0;
        run(16'd10000, 1'b0);
        run(16'd1, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
